// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Read-side engine for a simple synchronous dual-port BRAM. A start pulse
//   captures base_addr/length, the engine walks the BRAM read address and
//   presents the words on a valid/ready stream. A 2-entry skid buffer absorbs
//   the BRAM's one-cycle read latency so backpressure never drops or repeats
//   a word.
//
//   Optional feature macro: BRAM_READER_LAST_EN adds the m_last output.
//
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     start         start request, honoured only when idle
//     base_addr     first address read (captured on accepted start)
//     length        word count, 0..2**addr_width (captured on accepted start)
//     busy, done    transfer in progress / one-cycle completion pulse
//     addr_r        BRAM read address
//     mem_dout      BRAM registered read data
//     m_data, m_valid, m_ready   output stream
//     m_last        final-beat marker (BRAM_READER_LAST_EN only)
module bram_stream_reader #(
  parameter int unsigned addr_width = 10,
  parameter int unsigned data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] addr_r,
  input  logic [data_width-1:0] mem_dout,
  output logic [data_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef BRAM_READER_LAST_EN
  ,
  output logic                  m_last
`endif
);

  localparam int unsigned CW = addr_width + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [addr_width-1:0] ptr_q, ptr_d;
  logic [CW-1:0]         issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
  logic                  pending_q, pending_d;
  logic [1:0]            fill_q, fill_d;
  logic [data_width-1:0] head_q, head_d;
  logic [data_width-1:0] tail_q, tail_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef BRAM_READER_LAST_EN
  logic                  last_q, last_d;
`endif

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occupancy;

  // Next-state, counters and skid buffer
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    pending_d   = 1'b0;
    fill_d      = fill_q;
    head_d      = head_q;
    tail_d      = tail_q;
    issue       = 1'b0;

    push      = pending_q;
    pop       = valid_q && m_ready;
    // Words already buffered plus the one still in flight from the BRAM.
    occupancy = 3'(fill_q) + 3'(pending_q);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != CW'(0)) begin
            state_d     = ST_RUN;
            ptr_d       = base_addr;
            issue_cnt_d = length;
            beat_cnt_d  = length;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        // Only issue if the word will have a slot when it lands next cycle.
        issue = (issue_cnt_q != CW'(0)) && (occupancy < (3'd2 + 3'(pop)));
        if (issue) begin
          ptr_d       = ptr_q + addr_width'(1);
          issue_cnt_d = issue_cnt_q - CW'(1);
          pending_d   = 1'b1;
        end
        if (pop) begin
          beat_cnt_d = beat_cnt_q - CW'(1);
          if (beat_cnt_q == CW'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Skid buffer: head is the stream output, tail holds the second word.
    unique case ({push, pop})
      2'b10: begin
        if (fill_q == 2'd0) begin
          head_d = mem_dout;
        end else begin
          tail_d = mem_dout;
        end
        fill_d = fill_q + 2'd1;
      end
      2'b01: begin
        if (fill_q == 2'd2) begin
          head_d = tail_q;
        end
        fill_d = fill_q - 2'd1;
      end
      2'b11: begin
        if (fill_q == 2'd1) begin
          head_d = mem_dout;
        end else begin
          head_d = tail_q;
          tail_d = mem_dout;
        end
      end
      default: begin
      end
    endcase

    valid_d = (fill_d != 2'd0);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
`ifdef BRAM_READER_LAST_EN
    // The head is the final word when exactly one beat remains.
    last_d  = valid_d && (beat_cnt_d == CW'(1));
`endif
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      pending_q   <= 1'b0;
      fill_q      <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef BRAM_READER_LAST_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      pending_q   <= pending_d;
      fill_q      <= fill_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef BRAM_READER_LAST_EN
      last_q      <= last_d;
`endif
    end
  end

  assign addr_r  = ptr_q;
  assign m_data  = head_q;
  assign m_valid = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef BRAM_READER_LAST_EN
  assign m_last  = last_q;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Testbench for bram_stream_reader: behavioural BRAM, scoreboard of expected
// beats, a table of transfers and hand-written multi-cycle sequences.
module tb_bram_stream_reader;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 8;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
`ifdef BRAM_READER_LAST_EN
  logic          m_last;
`endif

  int checks = 0;
  int passed = 0;
  int beats  = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;
  beat_t exp_q[$];

  typedef struct {
    logic [AW-1:0] base;
    int            len;
    int            mode;       // 0: ready high, 1: toggling, 2: random
    logic [DW-1:0] exp_first;
  } vec_t;
  vec_t vecs[7];

  logic [DW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  // Behavioural BRAM read port: one-cycle registered read
  always @(posedge clk) mem_dout <= mem[addr_r];

  bram_stream_reader #(.addr_width(AW), .data_width(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .addr_r    (addr_r),
    .mem_dout  (mem_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
`ifdef BRAM_READER_LAST_EN
    ,
    .m_last    (m_last)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples on the falling edge; a handshake seen here completes on the next rise.
  task automatic monitor();
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(m_valid), 32'd1);
          check("stall_data", 32'(m_data), 32'(prev_data));
        end
        check("no_overflow",
              32'(dut.pending_q && (dut.fill_q == 2'd2) && !(m_valid && m_ready)), 32'd0);
`ifdef BRAM_READER_LAST_EN
        check("last_gated", 32'(m_last && !m_valid), 32'd0);
`endif
        if (m_valid && m_ready) begin
          beats++;
          check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat_data", 32'(m_data), 32'(e.data));
`ifdef BRAM_READER_LAST_EN
            check("beat_last", 32'(m_last), 32'(e.last));
`endif
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
      end
    end
  endtask

  // Called at posedge+1; leaves the bench one cycle after the accepting edge.
  task automatic start_xfer(input logic [AW-1:0] b, input int len);
    beat_t e;
    for (int i = 0; i < len; i++) begin
      e.data = mem[AW'(int'(b) + i)];
      e.last = (i == len - 1);
      exp_q.push_back(e);
    end
    start     = 1'b1;
    base_addr = b;
    length    = CW'(len);
    step();
    start     = 1'b0;
  endtask

  task automatic run_until_done(input int mode, input int budget, input logic [DW-1:0] exp_first);
    logic seen      = 1'b0;
    logic got_first = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      if (!got_first && m_valid) begin
        got_first = 1'b1;
        check("first_data", 32'(m_data), 32'(exp_first));
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((c % 2) == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      step();
      if (done) seen = 1'b1;
    end
    m_ready = 1'b1;
    check("first_seen", 32'(got_first), 32'd1);
    check("done_seen", 32'(seen), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    step();
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_addr_r"}, 32'(addr_r), 32'd0);
    check({tag, "_m_data"}, 32'(m_data), 32'd0);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
`ifdef BRAM_READER_LAST_EN
    check({tag, "_m_last"}, 32'(m_last), 32'd0);
`endif
  endtask

  initial begin
    int b0;
    int wrap_addr[4];

    vecs[0] = '{base: 10'd0,    len: 1,    mode: 0, exp_first: 8'h10};
    vecs[1] = '{base: 10'd1023, len: 1,    mode: 1, exp_first: 8'h0F};
    vecs[2] = '{base: 10'd10,   len: 7,    mode: 1, exp_first: 8'h1A};
    vecs[3] = '{base: 10'd500,  len: 16,   mode: 2, exp_first: 8'h04};
    vecs[4] = '{base: 10'd1020, len: 9,    mode: 2, exp_first: 8'h0C};
    vecs[5] = '{base: 10'd0,    len: 1024, mode: 0, exp_first: 8'h10};
    vecs[6] = '{base: 10'd700,  len: 5,    mode: 0, exp_first: 8'hCC};
    wrap_addr[0] = 1022;
    wrap_addr[1] = 1023;
    wrap_addr[2] = 0;
    wrap_addr[3] = 1;

    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    m_ready   = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'(i + 16);

    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    step();

    // Streaming: four back-to-back beats, first one two cycles after start
    b0 = beats;
    m_ready = 1'b1;
    start_xfer(10'd5, 4);
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) step();
      check("stream_valid", 32'(m_valid), 32'(k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) check("stream_data", 32'(m_data), 32'h15 + 32'(k) - 32'd2);
      check("stream_done", 32'(done), 32'(k == 6));
      check("stream_busy", 32'(busy), 32'(k <= 5));
      if (k <= 3) check("stream_addr", 32'(addr_r), 32'(5 + k));
`ifdef BRAM_READER_LAST_EN
      check("stream_last", 32'(m_last), 32'(k == 5));
`endif
    end
    check("stream_beats", 32'(beats - b0), 32'd4);

    // Backpressure: stall five cycles after the first beat, then toggle ready
    b0 = beats;
    m_ready = 1'b0;
    start_xfer(10'd5, 4);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k >= 2) begin
        check("bp_addr_held", 32'(addr_r), 32'd7);
        check("bp_valid", 32'(m_valid), 32'd1);
        check("bp_data", 32'(m_data), 32'h15);
      end
    end
    run_until_done(1, 40, 8'h15);
    check("bp_beats", 32'(beats - b0), 32'd4);

    // Wrap-around of the read address
    b0 = beats;
    m_ready = 1'b1;
    start_xfer(10'd1022, 4);
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) step();
      check("wrap_addr", 32'(addr_r), 32'(wrap_addr[k]));
      if (k == 2) check("wrap_first", 32'(m_data), 32'h0E);
    end
    run_until_done(0, 40, 8'h0F);
    check("wrap_beats", 32'(beats - b0), 32'd4);

    // Empty transfer
    b0 = beats;
    start_xfer(10'd3, 0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_valid", 32'(m_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("len0_after_done", 32'(done), 32'd0);
      check("len0_after_valid", 32'(m_valid), 32'd0);
    end
    check("len0_beats", 32'(beats - b0), 32'd0);

    // Start while busy is ignored
    b0 = beats;
    start_xfer(10'd100, 8);
    step();
    step();
    start     = 1'b1;
    base_addr = '0;
    length    = CW'(3);
    step();
    start     = 1'b0;
    run_until_done(0, 60, 8'h75);
    check("busy_start_beats", 32'(beats - b0), 32'd8);
    for (int k = 0; k < 4; k++) begin
      step();
      check("busy_start_no_valid", 32'(m_valid), 32'd0);
      check("busy_start_idle", 32'(busy), 32'd0);
    end

    // Table of transfers
    for (int v = 0; v < 7; v++) begin
      b0 = beats;
      start_xfer(vecs[v].base, vecs[v].len);
      run_until_done(vecs[v].mode, 4 * vecs[v].len + 20, vecs[v].exp_first);
      check("vec_beats", 32'(beats - b0), 32'(vecs[v].len));
    end

    // Reset in the middle of a stalled transfer, then a fresh transfer
    m_ready = 1'b0;
    start_xfer(10'd200, 8);
    repeat (3) step();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("midreset");
    exp_q.delete();
    rst     = 1'b0;
    m_ready = 1'b1;
    step();
    b0 = beats;
    start_xfer(10'd5, 4);
    run_until_done(0, 40, 8'h15);
    check("post_reset_beats", 32'(beats - b0), 32'd4);

    repeat (3) step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side engine for the simple synchronous dual-port block RAM. After a `start` pulse it drives the BRAM read address and collects the registered read data. It then presents `length` consecutive words, beginning at `base_addr`, on a valid/ready output stream. A 2-entry skid buffer absorbs the BRAM's one-cycle read latency, so backpressure never drops or duplicates a word. The block sits between a BRAM instance (filled through the write port) and any downstream stream consumer.

## Interface
- `addr_width`, 10, BRAM address width; memory depth is 2**addr_width
- `data_width`, 8, word width
- `clk`  input  1  clock; all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  start request; sampled only in IDLE
- `base_addr`  input  addr_width  first address read; captured on accepted start
- `length`  input  addr_width+1  number of words, 0..2**addr_width; captured on accepted start
- `busy`  output  1  high from the cycle after an accepted start until done
- `done`  output  1  one-cycle completion pulse
- `addr_r`  output  addr_width  BRAM read address (to BRAM `addr_r`)
- `mem_dout`  input  data_width  BRAM registered read data (from BRAM `dout`)
- `m_data`  output  data_width  stream data
- `m_valid`  output  1  stream valid
- `m_ready`  input  1  stream ready
- `m_last`  output  1  final beat marker (only with `BRAM_READER_LAST_EN`)

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 with `length`≠0 → RUN; `ptr`←`base_addr`, `issue_cnt`←`length`, `beat_cnt`←`length`.
  - `start`=1 with `length`=0 → DONE.
- RUN:
  - `addr_r` = `ptr` (register-driven).
  - An issue occurs in a cycle when `issue_cnt`≠0 and `fill + pending − pop < 2`, where:
    - `fill` is buffer occupancy (0..2),
    - `pending` means a read was issued last cycle,
    - `pop` = `m_valid && m_ready`.
  - On issue: `ptr`←`ptr`+1 modulo 2**addr_width (wraps 2**addr_width−1 → 0); `issue_cnt`−1; `pending`←1.
  - When `pending`=1, `mem_dout` is written into the buffer at the cycle end.
  - `m_valid` = (`fill`≠0); `m_data` = buffer head. Data and valid stay stable while `m_valid && !m_ready`.
  - Each pop decrements `beat_cnt`. The pop that takes `beat_cnt` to 0 → DONE.
- DONE: `done`=1 for exactly one cycle, then → IDLE.
- `busy` = (state ≠ IDLE) && !`done`.
- `start` outside IDLE is ignored; it is not queued.
- Counters are addr_width+1 bits, so a full-memory read (`length`=2**addr_width) is legal.
- Pushing into a full buffer must not occur by construction; the verification engineer checks this with an assertion.

## Timing
- Reset values: `addr_r`=0, `m_data`=0, `m_valid`=0, `busy`=0, `done`=0, `m_last`=0. Buffer is empty, `pending`=0, state is IDLE.
- Start accepted at edge E0 → first issue in cycle E0..E1 → BRAM data at E1..E2 → `m_valid`=1 from E2 onward. First-beat latency is 2 cycles after the accepting edge.
- With `m_ready` held high: one beat per cycle, no bubbles. `done` is high in the cycle after the last handshake.
- Empty read (`length`=0): `done` is high in the cycle after the accepting edge; `m_valid` never rises.
- Reset mid-operation: in-flight and buffered data are discarded. All outputs return to reset values on the next edge. The BRAM contents are untouched.

## Configuration
- `BRAM_READER_LAST_EN` defined:
  - `m_last` port exists.
  - It is high together with `m_valid` exactly when the head word is the final word of the transfer (`beat_cnt`=1).
  - It is 0 otherwise and at reset.
- Not defined: `m_last` port and its logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset: assert `rst` for 2 cycles during an active transfer → next cycle all outputs 0, state IDLE. A fresh start then reads correctly.
- Streaming: mem[i]=i+0x10, `base_addr`=5, `length`=4, `m_ready`=1 → `m_data` 0x15,0x16,0x17,0x18 on 4 consecutive cycles, starting 2 cycles after the start edge. `done` pulses the cycle after 0x18. `m_last` is high with 0x18 when enabled.
- Backpressure: same setup, `m_ready` low for 5 cycles after the first beat, then toggling 1/0 → all 4 words delivered in order with none lost or repeated. `m_data` is stable while stalled, and `addr_r` stops advancing once `fill`+`pending`=2.
- Wrap-around: `base_addr`=1022, `length`=4 → `addr_r` sequence 1022,1023,0,1, and data mem[1022],mem[1023],mem[0],mem[1].
- Length 0 and busy start: `length`=0 → `done` the next cycle, no `m_valid`. During a `length`=8 transfer, pulse `start` with `base_addr`=0 → ignored, and exactly 8 beats are delivered from the original base.
